// File: rtl/sync_fifo_dirflag.sv
// Single-clock FIFO. Full and empty come from Gray pointer equality plus a
// registered direction flag that remembers whether the write pointer last
// approached the read pointer from behind (filling) or from ahead (draining).
module sync_fifo_dirflag #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  sclr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH-1:0] wptr_nxt, rptr_nxt;
  logic [ADDR_WIDTH-1:0] wgray, rgray;
  logic                  dir;
  logic                  dir_set, dir_clr;
  logic                  ptr_eq;
  logic                  wr_fire, rd_fire;

  function automatic logic [ADDR_WIDTH-1:0] bin2gray(input logic [ADDR_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Status is decoded from registered pointers and the flag only.
  assign ptr_eq = (wgray == rgray);
  assign full   = ptr_eq & dir;
  assign empty  = ptr_eq & ~dir;

  // Reset wins over both requests; a blocked request never moves a pointer.
  assign wr_fire = wr_en & ~full & ~sclr;
  assign rd_fire = rd_en & ~empty & ~sclr;

  assign wptr_nxt = wr_fire ? wptr + ADDR_WIDTH'(1) : wptr;
  assign rptr_nxt = rd_fire ? rptr + ADDR_WIDTH'(1) : rptr;

  // Quadrant compare on the top two Gray bits: write one quadrant behind read
  // means we are filling, one quadrant ahead means we are draining.
  assign dir_set = (wgray[ADDR_WIDTH-1] ^ rgray[ADDR_WIDTH-2]) &
                   ~(wgray[ADDR_WIDTH-2] ^ rgray[ADDR_WIDTH-1]);
  assign dir_clr = ~(wgray[ADDR_WIDTH-1] ^ rgray[ADDR_WIDTH-2]) &
                   (wgray[ADDR_WIDTH-2] ^ rgray[ADDR_WIDTH-1]);

  // Storage array; contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_fire) mem[wptr] <= wr_data;
  end

  // Pointers, their Gray copies, direction flag and fill level.
  always_ff @(posedge clock) begin
    if (sclr) begin
      wptr  <= '0;
      rptr  <= '0;
      wgray <= '0;
      rgray <= '0;
      dir   <= 1'b0;
      level <= '0;
    end else begin
      wptr  <= wptr_nxt;
      rptr  <= rptr_nxt;
      wgray <= bin2gray(wptr_nxt);
      rgray <= bin2gray(rptr_nxt);
      if (dir_set)      dir <= 1'b1;
      else if (dir_clr) dir <= 1'b0;
      case ({wr_fire, rd_fire})
        2'b10:   level <= level + (ADDR_WIDTH + 1)'(1);
        2'b01:   level <= level - (ADDR_WIDTH + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Registered read port: one cycle from accepted read to valid data.
  always_ff @(posedge clock) begin
    if (sclr) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) rd_data <= mem[rptr];
    end
  end

endmodule
